// File: rtl/nand_gate_exerciser_if.sv
// rtl/nand_gate_exerciser_if.sv - control, gate and result signals of the NAND gate exerciser
interface nand_gate_exerciser_if #(
  parameter int ERR_W = 8
);
  logic             start;
  logic             loop;
  logic             c;
  logic             a;
  logic             b;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic [3:0]       fail_vec;

  modport master (
    output start, loop, c,
    input  a, b, busy, done, pass, err_cnt, fail_vec
  );

  modport slave (
    input  start, loop, c,
    output a, b, busy, done, pass, err_cnt, fail_vec
  );
endinterface

// File: rtl/nand_gate_exerciser.sv
// rtl/nand_gate_exerciser.sv - steps a 2-input NAND through all vectors and checks its output
module nand_gate_exerciser #(
  parameter int DWELL  = 4,
  parameter int SETTLE = 2,
  parameter int ERR_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nand_gate_exerciser_if.slave bus
);
  localparam int DCNT_W = $clog2(DWELL);
  localparam logic [DCNT_W-1:0] SAMPLE_AT = DCNT_W'(SETTLE);
  localparam logic [DCNT_W-1:0] LAST_AT   = DCNT_W'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

  state_e            state_q, state_d;
  logic [1:0]        vec_q, vec_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic              a_q, a_d;
  logic              b_q, b_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              perr_q, perr_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [3:0]        fail_q, fail_d;
  logic              mismatch;

  // a_q/b_q always equal vec_q while in RUN, so they form the expected-value reference
  assign mismatch = (state_q == RUN) && (dcnt_q == SAMPLE_AT) && (bus.c != ~(a_q & b_q));

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    dcnt_d  = dcnt_q;
    a_d     = a_q;
    b_d     = b_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    perr_d  = perr_q;
    err_d   = err_q;
    fail_d  = fail_q;

    if (mismatch) begin
      perr_d         = 1'b1;
      fail_d[vec_q]  = 1'b1;
      if (err_q != {ERR_W{1'b1}}) err_d = err_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        {a_d, b_d} = 2'b00;
        if (bus.start) begin
          state_d = RUN;
          vec_d   = 2'd0;
          dcnt_d  = '0;
          err_d   = '0;
          fail_d  = '0;
          perr_d  = 1'b0;
        end
      end
      RUN: begin
        dcnt_d = dcnt_q + 1'b1;
        if (dcnt_q == LAST_AT) begin
          dcnt_d = '0;
          if (vec_q == 2'd3) begin
            state_d    = FIN;
            done_d     = 1'b1;
            // perr_d already includes a sample taken on this same edge
            pass_d     = ~perr_d;
            {a_d, b_d} = 2'b11;
          end else begin
            vec_d      = vec_q + 2'd1;
            {a_d, b_d} = vec_q + 2'd1;
          end
        end
      end
      FIN: begin
        {a_d, b_d} = 2'b00;
        vec_d      = 2'd0;
        dcnt_d     = '0;
        if (bus.loop) begin
          state_d = RUN;
          perr_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= 2'd0;
      dcnt_q  <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      perr_q  <= 1'b0;
      err_q   <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      dcnt_q  <= dcnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      perr_q  <= perr_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  assign bus.a        = a_q;
  assign bus.b        = b_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.err_cnt  = err_q;
  assign bus.fail_vec = fail_q;
endmodule

// File: doc/nand_gate_exerciser.md
# nand_gate_exerciser

Self-checking stimulus/checker stage that wraps the team's 2-input NAND gate on the board. It drives the gate inputs `a`, `b` through all four input vectors and samples the gate output `c`. Each sample is compared against the expected NAND value, and the block reports pass/fail, an error count and a per-vector failure mask. It sits directly around the gate: `a`/`b` feed the gate upstream, and `c` returns from it downstream.

## Interface
- `DWELL`, 4: cycles each vector is held; legal range 2..255.
- `SETTLE`, 2: cycle offset within the dwell at which `c` is sampled; must satisfy 1 <= SETTLE < DWELL.
- `ERR_W`, 8: width of the error counter.
- `clk` input 1: single system clock, rising-edge.
- `rst_n` input 1: reset is asynchronous and active-low.
- `start` input 1: launches a run when sampled high in IDLE.
- `loop` input 1: when high at end of a pass, the next pass starts immediately.
- `c` input 1: gate output under test, same clock domain, not synchronised.
- `a` output 1: gate input A, registered.
- `b` output 1: gate input B, registered.
- `busy` output 1: high in RUN and FIN.
- `done` output 1: one-cycle pulse at the end of each pass.
- `pass` output 1: result of the last completed pass.
- `err_cnt` output ERR_W: saturating mismatch count since the last launch from IDLE.
- `fail_vec` output 4: sticky mask; bit `{a,b}` is set if that vector ever mismatched since launch.

## Operation
- States are IDLE, RUN and FIN. Internal registers: `vec[1:0]` and `dcnt` (dwell counter, width ceil(log2(DWELL))).
- **IDLE**
  - Outputs: `a`=`b`=0, `busy`=0.
  - `start`=1 moves to RUN with `vec`=0 and `dcnt`=0.
  - On that launch, `err_cnt` and `fail_vec` clear to 0; `pass` keeps its previous value.
- **RUN**
  - `{a,b}` = `vec`. `dcnt` increments every cycle.
  - At the edge where `dcnt`==SETTLE, `c` is compared with `~(a&b)`. On mismatch:
    - `err_cnt` increments, saturating at 2^ERR_W-1.
    - `fail_vec[vec]` is set.
  - At the edge where `dcnt`==DWELL-1: `dcnt` returns to 0. If `vec`==3, go to FIN; otherwise `vec` increments.
- **FIN** (one cycle)
  - `done`=1.
  - `pass` = 1 if no mismatch was recorded in this pass, else 0.
  - `a`/`b` hold 1/1.
  - Next state:
    - `loop`=1: RUN with `vec`=0 and `dcnt`=0; `err_cnt`/`fail_vec` NOT cleared, so they accumulate across passes.
    - `loop`=0: IDLE.
- `start` is ignored while `busy`=1. If `start` is held high through FIN→IDLE, a new run launches on the first IDLE cycle.
- Per-pass mismatch is tracked by an internal flag cleared at each pass start. `pass` is per-pass; `err_cnt`/`fail_vec` are per-launch.
- Reset, including mid-run: state IDLE immediately. `a`=`b`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `fail_vec`=0, `vec`=0, `dcnt`=0.

## Timing
- Every output is a register output; no combinational path from `c` or `start` to any output.
- Launch: `start` is sampled high at edge E0. From E0, `a`,`b` = 0,0 and `busy`=1.
- Vector k is driven from edge E0+k·DWELL up to E0+(k+1)·DWELL.
- `c` for vector k is sampled at edge E0+k·DWELL+SETTLE+1. The gate therefore has SETTLE+1 cycles to respond.
- FIN is entered at E0+4·DWELL. `done`=1 and the updated `pass` appear together from that edge.
- `done` drops at E0+4·DWELL+1. At that edge, `busy` drops if `loop`=0; if `loop`=1, vector 0 is driven again.
- Pass period with `loop`=1 is 4·DWELL+1 cycles.

## Test plan
1. Correct NAND model on `c`, defaults, `start` pulse at E0:
   - `{a,b}` steps 00, 01, 10, 11 for 4 cycles each.
   - `done` pulses at E0+16.
   - Result: `pass`=1, `err_cnt`=0, `fail_vec`=0000.
2. AND model on `c` (inverted gate): `err_cnt`=4, `fail_vec`=1111, `pass`=0.
3. `c` stuck at 1: only vector 11 fails, so `err_cnt`=1, `fail_vec`=1000, `pass`=0.
4. ERR_W=2, `c` stuck at 0, `loop`=1:
   - Pass 1 gives `err_cnt`=3 (vectors 00, 01, 10); `err_cnt` stays 3 in later passes (saturation).
   - `done` pulses every 17 cycles.
   - After `loop` is dropped, the block returns to IDLE after the current FIN.
5. `start` re-pulsed during RUN: no restart and the timing is unchanged. Then `rst_n` low at vector 10: on the same cycle, all outputs go to 0 and `busy`=0. After release, a fresh `start` gives a full clean pass.
6. `c` model with 3-cycle latency, SETTLE=1 versus SETTLE=3 (DWELL=4): SETTLE=1 reports mismatches; SETTLE=3 gives `pass`=1.
